// File: rtl/ssd_pkg.sv
// Purpose: shared character codes and seven-segment patterns for the scroller.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Patterns are active-low, bit0 = segment a ... bit6 = segment g.
package ssd_pkg;

   localparam logic [2:0] CH_BLANK = 3'd0;
   localparam logic [2:0] CH_H     = 3'd1;
   localparam logic [2:0] CH_E     = 3'd2;
   localparam logic [2:0] CH_L     = 3'd3;
   localparam logic [2:0] CH_O     = 3'd4;
   localparam logic [2:0] CH_D     = 3'd5;
   localparam logic [2:0] CH_ONE   = 3'd6;
   localparam logic [2:0] CH_DASH  = 3'd7;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_H     = 7'h09;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_L     = 7'h47;
   localparam logic [6:0] SEG_O     = 7'h40;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SSD_BLANK = 7'h7F;

endpackage

// File: rtl/scroll_display_ctrl_char_to_ssd.sv
// Purpose: decode a 3-bit character code to an active-low 7-segment pattern.
// Latency: combinational (0 cycles); the parent registers the result.
// Backpressure: none.
// Ports: i_code = character code, o_seg = segments g..a (active-low).
module char_to_ssd
   import ssd_pkg::*;
(
   input  logic [2:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SSD_BLANK;
      case (i_code)
         CH_BLANK: o_seg = SEG_BLANK;
         CH_H:     o_seg = SEG_H;
         CH_E:     o_seg = SEG_E;
         CH_L:     o_seg = SEG_L;
         CH_O:     o_seg = SEG_O;
         CH_D:     o_seg = SEG_D;
         CH_ONE:   o_seg = SEG_ONE;
         CH_DASH:  o_seg = SEG_DASH;
         default:  o_seg = SSD_BLANK;
      endcase
   end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Purpose: ring-buffer message scroller driving a 4-digit 7-segment window.
// Latency: advance/write take effect at the edge; HEX follows one edge later.
// Backpressure: none; every in-range write is accepted and acked next cycle.
// Ports: CLOCK_50/Resetn clock and async reset; run/step scroll control;
//        wr_en/wr_addr/wr_data buffer write with wr_ack; tick/pos status;
//        HEX3..HEX0 registered active-low segments (HEX3 = head character).
module scroll_display_ctrl
   import ssd_pkg::*;
#(
   parameter  int TICK_DIV = 50_000_000,
   parameter  int MSG_LEN  = 8,
   localparam int AW       = $clog2(MSG_LEN)
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   input  logic          run,
   input  logic          step,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [2:0]    wr_data,
   output logic          wr_ack,
   output logic          tick,
   output logic [AW-1:0] pos,
   output logic [6:0]    HEX3,
   output logic [6:0]    HEX2,
   output logic [6:0]    HEX1,
   output logic [6:0]    HEX0
);

   localparam int          PW    = $clog2(TICK_DIV);
   localparam logic [AW:0] LEN_W = (AW+1)'(MSG_LEN);

   logic [PW-1:0] r_presc;
   logic [AW-1:0] r_pos;
   logic [2:0]    r_buf [MSG_LEN];
   logic          r_tick;
   logic          r_ack;
   logic [6:0]    r_hex [4];

   logic          w_adv;
   logic          w_wr_ok;
   logic          w_presc_end;
   logic [6:0]    w_seg [4];

   // Sum is at most (MSG_LEN-1)+3, so one conditional subtract is a full mod.
   function automatic logic [AW-1:0] f_wrap(input logic [AW:0] i_sum);
      if (i_sum >= LEN_W)
         return AW'(i_sum - LEN_W);
      return i_sum[AW-1:0];
   endfunction

   assign w_presc_end = (r_presc == PW'(TICK_DIV - 1));
   // Step pulses only count while paused; while running the prescaler rules.
   assign w_adv       = run ? w_presc_end : step;
   // Non-power-of-two buffers leave a hole in the address space; drop those.
   assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < LEN_W);

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_presc <= '0;
         r_pos   <= '0;
         r_tick  <= 1'b0;
         r_ack   <= 1'b0;
         for (int i = 0; i < MSG_LEN; i++)
            r_buf[i] <= CH_BLANK;
      end else begin
         // Held at zero while paused so resuming always waits a full period.
         if (!run || w_presc_end)
            r_presc <= '0;
         else
            r_presc <= r_presc + PW'(1);

         if (w_adv)
            r_pos <= (r_pos == AW'(MSG_LEN - 1)) ? '0 : r_pos + AW'(1);

         if (w_wr_ok)
            r_buf[wr_addr] <= wr_data;

         r_tick <= w_adv;
         r_ack  <= w_wr_ok;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_dig
      logic [AW-1:0] w_idx;
      assign w_idx = f_wrap({1'b0, r_pos} + (AW+1)'(gi));
      char_to_ssd u_dec (
         .i_code (r_buf[w_idx]),
         .o_seg  (w_seg[gi])
      );
   end

   // Window is sampled from the registered buffer/head, so a write or advance
   // at one edge shows on the pins at the next.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 4; i++)
            r_hex[i] <= SSD_BLANK;
      end else begin
         for (int i = 0; i < 4; i++)
            r_hex[i] <= w_seg[i];
      end
   end

   assign pos    = r_pos;
   assign tick   = r_tick;
   assign wr_ack = r_ack;
   assign HEX3   = r_hex[0];
   assign HEX2   = r_hex[1];
   assign HEX1   = r_hex[2];
   assign HEX0   = r_hex[3];

endmodule

// File: tb/tb_scroll_display_ctrl.sv
module tb_scroll_display_ctrl;

   localparam int          LEN [2] = '{8, 6};
   localparam int          TD  [2] = '{4, 3};
   localparam logic [6:0]  SEG [8] = '{7'h7F, 7'h09, 7'h06, 7'h47,
                                       7'h40, 7'h21, 7'h79, 7'h3F};

   logic       clk    = 1'b0;
   logic       Resetn = 1'b0;
   logic       run    = 1'b0;
   logic       step   = 1'b0;
   logic       wen  [2];
   logic [2:0] wadr [2];
   logic [2:0] wdat [2];
   logic       o_ack  [2];
   logic       o_tick [2];
   logic [2:0] o_pos  [2];
   logic [6:0] o_hex  [2][4];

   int n_chk = 0;
   int n_err = 0;

   // behavioural model state
   int   m_buf [2][16];
   int   m_pos [2];
   int   m_cnt [2];
   logic m_adv [2];
   int   e_hex [2][4];
   int   e_tick [2];
   int   e_ack  [2];

   always #5 clk = ~clk;

   scroll_display_ctrl #(.TICK_DIV(4), .MSG_LEN(8)) dut8 (
      .CLOCK_50(clk), .Resetn(Resetn), .run(run), .step(step),
      .wr_en(wen[0]), .wr_addr(wadr[0]), .wr_data(wdat[0]),
      .wr_ack(o_ack[0]), .tick(o_tick[0]), .pos(o_pos[0]),
      .HEX3(o_hex[0][0]), .HEX2(o_hex[0][1]), .HEX1(o_hex[0][2]), .HEX0(o_hex[0][3])
   );

   scroll_display_ctrl #(.TICK_DIV(3), .MSG_LEN(6)) dut6 (
      .CLOCK_50(clk), .Resetn(Resetn), .run(run), .step(step),
      .wr_en(wen[1]), .wr_addr(wadr[1]), .wr_data(wdat[1]),
      .wr_ack(o_ack[1]), .tick(o_tick[1]), .pos(o_pos[1]),
      .HEX3(o_hex[1][0]), .HEX2(o_hex[1][1]), .HEX1(o_hex[1][2]), .HEX0(o_hex[1][3])
   );

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Model: count clocks spent running; every TD-th one advances the head.
   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) m_buf[d][i] = 0;
         m_pos[d] = 0; m_cnt[d] = 0; e_tick[d] = 0; e_ack[d] = 0;
         for (int i = 0; i < 4; i++) e_hex[d][i] = 'h7F;
      end
      forever begin
         @(posedge clk or negedge Resetn);
         for (int d = 0; d < 2; d++) begin
            if (!Resetn) begin
               for (int i = 0; i < 16; i++) m_buf[d][i] = 0;
               m_pos[d] = 0; m_cnt[d] = 0; e_tick[d] = 0; e_ack[d] = 0;
               for (int i = 0; i < 4; i++) e_hex[d][i] = 'h7F;
            end else begin
               for (int i = 0; i < 4; i++)
                  e_hex[d][i] = SEG[m_buf[d][(m_pos[d] + i) % LEN[d]]];
               if (run) begin
                  m_cnt[d] = m_cnt[d] + 1;
                  m_adv[d] = (m_cnt[d] == TD[d]);
                  if (m_adv[d]) m_cnt[d] = 0;
               end else begin
                  m_cnt[d] = 0;
                  m_adv[d] = step;
               end
               e_ack[d] = 0;
               if (wen[d] && int'(wadr[d]) < LEN[d]) begin
                  m_buf[d][wadr[d]] = int'(wdat[d]);
                  e_ack[d] = 1;
               end
               if (m_adv[d]) m_pos[d] = (m_pos[d] + 1) % LEN[d];
               e_tick[d] = m_adv[d] ? 1 : 0;
            end
         end
      end
   end

   // Compare every cycle, away from the rising edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_pos", d),  int'(o_pos[d]),  m_pos[d]);
         chk($sformatf("d%0d_tick", d), int'(o_tick[d]), e_tick[d]);
         chk($sformatf("d%0d_ack", d),  int'(o_ack[d]),  e_ack[d]);
         for (int i = 0; i < 4; i++)
            chk($sformatf("d%0d_hex%0d", d, 3 - i), int'(o_hex[d][i]), e_hex[d][i]);
      end
   end

   int p;
   int ntk;
   logic [2:0] msg [8];

   initial begin
      msg = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
      for (int d = 0; d < 2; d++) begin
         wen[d] = 1'b0; wadr[d] = '0; wdat[d] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_pos", int'(o_pos[0]), 0);
      chk("rst_hex3", int'(o_hex[0][0]), 'h7F);
      chk("rst_hex0", int'(o_hex[0][3]), 'h7F);
      Resetn = 1'b1;

      // load HELLO + blanks
      for (int i = 0; i < 8; i++) begin
         wen[0] = 1'b1; wadr[0] = 3'(i); wdat[0] = msg[i];
         @(negedge clk);
         chk("load_ack", int'(o_ack[0]), 1);
      end
      wen[0] = 1'b0;
      @(negedge clk);
      chk("load_hex3", int'(o_hex[0][0]), 'h09);
      chk("load_hex2", int'(o_hex[0][1]), 'h06);
      chk("load_hex1", int'(o_hex[0][2]), 'h47);
      chk("load_hex0", int'(o_hex[0][3]), 'h47);

      // first timed advance after 4 running edges
      run = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_adv_tick", int'(o_tick[0]), 0);
      @(negedge clk);
      chk("adv1_tick", int'(o_tick[0]), 1);
      chk("adv1_pos", int'(o_pos[0]), 1);
      @(negedge clk);
      chk("adv1_hex3", int'(o_hex[0][0]), 'h06);
      chk("adv1_hex2", int'(o_hex[0][1]), 'h47);
      chk("adv1_hex1", int'(o_hex[0][2]), 'h47);
      chk("adv1_hex0", int'(o_hex[0][3]), 'h40);

      // wrap
      for (int i = 0; i < 100 && o_pos[0] != 3'd6; i++) @(negedge clk);
      chk("wrap_pos6", int'(o_pos[0]), 6);
      @(negedge clk);
      chk("wrap_hex3", int'(o_hex[0][0]), 'h7F);
      chk("wrap_hex2", int'(o_hex[0][1]), 'h7F);
      chk("wrap_hex1", int'(o_hex[0][2]), 'h09);
      chk("wrap_hex0", int'(o_hex[0][3]), 'h06);
      for (int i = 0; i < 20 && !o_tick[0]; i++) @(negedge clk);
      chk("wrap_pos7", int'(o_pos[0]), 7);
      @(negedge clk);
      for (int i = 0; i < 20 && !o_tick[0]; i++) @(negedge clk);
      chk("wrap_pos0", int'(o_pos[0]), 0);

      // pause: no ticks for 20 cycles
      run = 1'b0;
      ntk = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_tick[0]) ntk++;
      end
      chk("pause_ticks", ntk, 0);

      // single steps
      for (int k = 0; k < 3; k++) begin
         p = int'(o_pos[0]);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
         chk("step_tick", int'(o_tick[0]), 1);
         chk("step_pos", int'(o_pos[0]), (p + 1) % 8);
         @(negedge clk);
      end

      // step while running is ignored
      p = int'(o_pos[0]);
      run = 1'b1; step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("run_step_pos", int'(o_pos[0]), p);
      chk("run_step_tick", int'(o_tick[0]), 0);
      run = 1'b0;
      @(negedge clk);

      // write the next head slot on the advance edge
      p = int'(o_pos[0]);
      step = 1'b1; wen[0] = 1'b1; wadr[0] = 3'((p + 1) % 8); wdat[0] = 3'd6;
      @(negedge clk);
      step = 1'b0; wen[0] = 1'b0;
      chk("wadv_ack", int'(o_ack[0]), 1);
      chk("wadv_pos", int'(o_pos[0]), (p + 1) % 8);
      @(negedge clk);
      chk("wadv_hex3", int'(o_hex[0][0]), 'h79);

      // out-of-range address on the 6-entry buffer
      wen[1] = 1'b1; wadr[1] = 3'd7; wdat[1] = 3'd5;
      @(negedge clk);
      wen[1] = 1'b0;
      chk("oor_ack", int'(o_ack[1]), 0);
      @(negedge clk);

      // randomized traffic on both instances
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step = ($urandom_range(0, 3) == 0);
         for (int d = 0; d < 2; d++) begin
            wen[d]  = $urandom_range(0, 1) == 1;
            wadr[d] = 3'($urandom_range(0, 7));
            wdat[d] = 3'($urandom_range(0, 7));
         end
         @(negedge clk);
      end

      // asynchronous reset mid-run, checked before any edge
      run = 1'b1; step = 1'b0;
      wen[0] = 1'b1; wadr[0] = 3'd2; wdat[0] = 3'd7;
      repeat (5) @(negedge clk);
      #2 Resetn = 1'b0;
      #1;
      chk("arst_pos", int'(o_pos[0]), 0);
      chk("arst_tick", int'(o_tick[0]), 0);
      chk("arst_ack", int'(o_ack[0]), 0);
      for (int i = 0; i < 4; i++)
         chk("arst_hex", int'(o_hex[0][i]), 'h7F);
      wen[0] = 1'b0;
      @(negedge clk);
      Resetn = 1'b1;
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
